// File: rtl/fcmp_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fcmp_pipe                                                    |
// | Description : Pipelined floating-point compare/select unit (FEQ, FLT, FLE, |
// |               FMIN, FMAX) with valid/ready backpressure and a caller tag.  |
// |               Optional macro FCMP_NAN_EN adds NaN handling and port nv.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fcmp_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int LAT   = 2,
   parameter int TAG_W = 5,
   localparam int W     = 1 + EXP_W + MAN_W,
   localparam int OCC_W = $clog2(LAT + 1)
) (
   input  logic             sys_clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [W-1:0]     x1,
   input  logic [W-1:0]     x2,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     y,
   output logic [TAG_W-1:0] out_tag,
`ifdef FCMP_NAN_EN
   output logic             nv,
`endif
   output logic [OCC_W-1:0] occ
);

   localparam logic [2:0]   c_OP_FEQ   = 3'b000;
   localparam logic [2:0]   c_OP_FLT   = 3'b001;
   localparam logic [2:0]   c_OP_FLE   = 3'b010;
   localparam logic [2:0]   c_OP_FMIN  = 3'b011;
   localparam logic [2:0]   c_OP_FMAX  = 3'b100;
   // 1.0: sign 0, biased exponent 2^(EXP_W-1)-1, mantissa 0
   localparam logic [W-1:0] c_ONE      = {2'b00, {(EXP_W-1){1'b1}}, {MAN_W{1'b0}}};
   localparam logic [W-1:0] c_NEG_ZERO = {1'b1, {(W-1){1'b0}}};
`ifdef FCMP_NAN_EN
   localparam logic [W-1:0] c_CNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
`endif

   logic             w_lt;
   logic             w_eq;
   logic             w_both_zero;
   logic [W-1:0]     w_res;
   logic             w_nv;
   logic             w_acc;
   logic             w_pop;
   logic [LAT:1]     w_en;
   logic [LAT:1]     r_v;
   logic [W-1:0]     r_y   [1:LAT];
   logic [TAG_W-1:0] r_tag [1:LAT];
   logic [LAT:1]     r_nv;
   logic [OCC_W-1:0] r_occ;
`ifdef FCMP_NAN_EN
   logic             w_nan1;
   logic             w_nan2;
   logic             w_snan1;
   logic             w_snan2;
`endif

   // Sign-magnitude ordering of the two operands; +0 and -0 are equal
   always_comb begin
      w_both_zero = (x1[W-2:0] == '0) && (x2[W-2:0] == '0);
      w_eq        = (x1 == x2) || w_both_zero;
      if (w_both_zero)
         w_lt = 1'b0;
      else if (x1[W-1] != x2[W-1])
         w_lt = x1[W-1];
      else if (x1[W-1])
         w_lt = x1[W-2:0] > x2[W-2:0];
      else
         w_lt = x1[W-2:0] < x2[W-2:0];
   end

`ifdef FCMP_NAN_EN
   // NaN classification: exponent all ones, mantissa non-zero; quiet when mantissa MSB set
   always_comb begin
      w_nan1  = (&x1[W-2:MAN_W]) && (|x1[MAN_W-1:0]);
      w_nan2  = (&x2[W-2:MAN_W]) && (|x2[MAN_W-1:0]);
      w_snan1 = w_nan1 && !x1[MAN_W-1];
      w_snan2 = w_nan2 && !x2[MAN_W-1];
   end
`endif

   // Stage-1 result selection per opcode
   always_comb begin
      w_res = '0;
      w_nv  = 1'b0;
      case (op)
         c_OP_FEQ:  w_res = w_eq ? c_ONE : '0;
         c_OP_FLT:  w_res = w_lt ? c_ONE : '0;
         c_OP_FLE:  w_res = (w_lt || w_eq) ? c_ONE : '0;
         c_OP_FMIN: begin
            if (w_lt)
               w_res = x1;
            else if (w_eq)
               w_res = w_both_zero ? c_NEG_ZERO : x1;
            else
               w_res = x2;
         end
         c_OP_FMAX: begin
            if (w_lt)
               w_res = x2;
            else if (w_eq)
               w_res = w_both_zero ? '0 : x1;
            else
               w_res = x1;
         end
         default:   w_res = '0;
      endcase
`ifdef FCMP_NAN_EN
      // NaN operands override the ordinary ordering
      if (w_nan1 || w_nan2) begin
         if (op == c_OP_FEQ || op == c_OP_FLT || op == c_OP_FLE)
            w_res = '0;
         else if (op == c_OP_FMIN || op == c_OP_FMAX)
            w_res = (w_nan1 && w_nan2) ? c_CNAN : (w_nan1 ? x2 : x1);
      end
      w_nv = ((w_nan1 || w_nan2) && (op == c_OP_FLT || op == c_OP_FLE)) || w_snan1 || w_snan2;
`endif
   end

   // Stage k may load when it or any later stage has a hole, or the consumer takes the head
   generate
      for (genvar k = 1; k <= LAT; k++) begin : g_en
         assign w_en[k] = !(&r_v[LAT:k]) || out_ready;
      end
   endgenerate

   assign in_ready  = w_en[1];
   assign out_valid = r_v[LAT];
   assign w_acc     = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;

   // Stage valid bits: cleared on reset, shifted forward wherever a stage is enabled
   always_ff @(posedge sys_clk) begin
      if (!rstn) begin
         r_v <= '0;
      end else begin
         if (w_en[1])
            r_v[1] <= in_valid;
         for (int k = 2; k <= LAT; k++)
            if (w_en[k])
               r_v[k] <= r_v[k-1];
      end
   end

   // Stage payload: result evaluated once in stage 1, later stages are pure delay
   always_ff @(posedge sys_clk) begin
      if (w_en[1]) begin
         r_y[1]   <= w_res;
         r_tag[1] <= in_tag;
         r_nv[1]  <= w_nv;
      end
      for (int k = 2; k <= LAT; k++) begin
         if (w_en[k]) begin
            r_y[k]   <= r_y[k-1];
            r_tag[k] <= r_tag[k-1];
            r_nv[k]  <= r_nv[k-1];
         end
      end
   end

   // Occupancy: +1 on acceptance, -1 on output transfer, unchanged when both occur
   always_ff @(posedge sys_clk) begin
      if (!rstn)
         r_occ <= '0;
      else if (w_acc && !w_pop)
         r_occ <= r_occ + OCC_W'(1);
      else if (!w_acc && w_pop)
         r_occ <= r_occ - OCC_W'(1);
   end

   assign occ     = r_occ;
   assign y       = out_valid ? r_y[LAT] : '0;
   assign out_tag = out_valid ? r_tag[LAT] : '0;
`ifdef FCMP_NAN_EN
   assign nv      = out_valid && r_nv[LAT];
`endif

endmodule
`default_nettype wire

// File: doc/fcmp_pipe.md
Name: fcmp_pipe

Overview:
Parametrised floating-point compare/select unit with a configurable pipeline depth and valid/ready backpressure.
Ops: FEQ, FLT, FLE, FMIN, FMAX on IEEE-style sign/exponent/mantissa operands of configurable width, with a caller tag carried alongside each result.
Sits in the FPU beside the add/mul units and drives the same writeback arbiter, so it must hold its result under stall.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, mantissa field width; operand width W = 1+EXP_W+MAN_W
LAT, 2, pipeline stages, legal range 1..4; input-to-output latency in cycles
TAG_W, 5, width of the tag carried with each operation

Ports:
sys_clk  in  1  clock
rstn  in  1  reset; rstn is synchronous and active-low, and the clock is sys_clk
in_valid  in  1  operation offered
in_ready  out  1  unit accepts the operation this cycle
op  in  3  000 FEQ, 001 FLT, 010 FLE, 011 FMIN, 100 FMAX, others illegal
x1  in  W  operand 1
x2  in  W  operand 2
in_tag  in  TAG_W  caller tag
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
y  out  W  result
out_tag  out  TAG_W  tag of the result
occ  out  $clog2(LAT+1)  number of valid pipeline stages

Behaviour:
- Transfer rule: input transfers when in_valid && in_ready. Output transfers when out_valid && out_ready.
- Pipeline: LAT stage registers, each with its own valid bit.
  - Stage k advances when stage k+1 is empty or advancing.
  - The last stage advances on out_ready.
  - in_ready = !v[1] || adv[1], which is combinational from out_ready through the chain.
- Latency and throughput: with out_ready held at 1, a result appears exactly LAT cycles after acceptance, at one op per cycle.
- Stall: when out_valid=1 and out_ready=0, y, out_tag and every stage hold. No op is dropped or duplicated, and order is preserved.
- Output gating: y and out_tag are forced to 0 whenever out_valid=0.
- occ is incremented on acceptance and decremented on output transfer. It is unchanged when both happen in the same cycle, and never exceeds LAT.
- Reset:
  - Clears all stage valid bits, occ=0, out_valid=0, y=0, out_tag=0.
  - in_ready=1 in the first cycle after reset release.
  - Reset asserted mid-operation discards all in-flight ops with no partial output.
- Ordering: sign-magnitude total order.
  - +0 and -0 compare equal.
  - Same sign: the exponent is compared first, then the mantissa, both unsigned. The sense of the comparison is inverted when both operands are negative.
  - Differing signs (not both zero): the negative operand is smaller.
- Compare-op results (FEQ/FLT/FLE): y = 1.0 when true, else 0.
  - 1.0 = sign 0, exponent 2^(EXP_W-1)-1, mantissa 0 (0x3f800000 at defaults).
- Select-op results:
  - FMIN returns the smaller operand bit-exactly; FMAX returns the larger.
  - On equality, x1 is returned, except ±0: FMIN returns -0 and FMAX returns +0.
- Illegal op: the op is accepted and flows normally, with y=0.
- Pipeline split: comparison is evaluated in stage 1 and the result is registered. Stages 2..LAT are pure delay.
- Tag: in_tag flows unmodified with its op.

Optional Feature:
Macro FCMP_NAN_EN.
- Defined:
  - NaN detection is added: exponent all ones and mantissa non-zero.
  - Any NaN operand makes FEQ/FLT/FLE return 0.
  - FMIN/FMAX return the non-NaN operand. If both are NaN, they return canonical NaN: sign 0, exponent all ones, mantissa MSB 1 and other bits 0.
  - Adds output port nv (1 bit), aligned with y and forced to 0 when out_valid=0.
  - nv=1 for FLT/FLE with any NaN, and for any op with a signalling NaN (mantissa MSB 0).
- Not defined:
  - NaN patterns are ordered as ordinary sign-magnitude values.
  - Port nv is absent.

Test Plan:
- LAT=2, out_ready=1, FLE x1=0x3f800000, x2=0x40000000, tag 3 -> exactly 2 cycles later out_valid=1, y=0x3f800000, out_tag=3.
- FLT 0xbf800000 vs 0xc0000000 -> y=0. FEQ 0x00000000 vs 0x80000000 -> y=0x3f800000. FMIN of the same pair -> y=0x80000000.
- Back-to-back FMAX then FMIN on 0x3f800000 vs 0xc0000000 -> consecutive outputs 0x3f800000 then 0xc0000000, tags in order.
- LAT=2, out_ready=0, 3 ops offered -> 2 accepted, in_ready=0 on the third, occ=2. Raising out_ready drains all 3 in order with no loss.
- Reset asserted with occ=2 and out_valid=1 -> next cycle out_valid=0, y=0, occ=0, in_ready=1. The old ops never reappear.
- With FCMP_NAN_EN: FLE 0x7fc00000 vs 0x3f800000 -> y=0, nv=1. FMAX 0x7fa00000 vs 0x7fc00000 -> y=0x7fc00000, nv=1.
